// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_t          state, next_state;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic            neg;
    logic            div_zero;
    logic [XLEN-1:0] opnd;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] result_q;

    // Operand decode on the live inputs, captured while IDLE.
    logic            a_signed_op, b_signed_op, sa, sb, accept, early;
    logic            div_zero_in, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_signed_op = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                         (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed_op = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sa          = a_signed_op & srca[XLEN-1];
    assign sb          = b_signed_op & srcb[XLEN-1];
    assign a_mag       = sa ? -srca : srca;
    assign b_mag       = sb ? -srcb : srcb;
    // Remainder follows the dividend's sign; products and quotients follow sa^sb.
    assign neg_in      = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
    assign div_zero_in = funct3[2] && (srcb == '0);
    assign accept      = start & ~flush;

`ifdef MULDIV_EARLY_OUT_EN
    logic            ovf_in;
    logic [XLEN-1:0] early_result;

    assign ovf_in = funct3[2] && !funct3[0] &&
                    (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
    assign early  = accept & (div_zero_in | ovf_in);
    always_comb begin
        if (div_zero_in) early_result = funct3[1] ? srca : '1;
        else             early_result = funct3[1] ? '0 : srca;
    end
`else
    assign early = 1'b0;
`endif

    // One iteration of either loop; acc holds {partial product | remainder, multiplier | quotient}.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
    logic [XLEN-1:0]   quo, rem, final_value;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign acc_next  = op[2] ? div_next : mul_next;

    assign prod = neg ? -acc_next : acc_next;
    assign quo  = acc_next[XLEN-1:0];
    assign rem  = acc_next[2*XLEN-1:XLEN];

    always_comb begin
        final_value = prod[XLEN-1:0];
        case (op)
            3'b000:                 final_value = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_value = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_value = div_zero ? '1 : (neg ? -quo : quo);
            default:                final_value = neg ? -rem : rem;
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = early ? DONE : RUN;
            RUN:     if (count == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // NOTE: every datapath register is reset, so a reset mid-op leaves no
    // trace of the aborted operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            op       <= '0;
            neg      <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    op       <= funct3;
                    neg      <= neg_in;
                    div_zero <= div_zero_in;
                    opnd     <= funct3[2] ? b_mag : a_mag;
                    acc      <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                    count    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early) result_q <= early_result;
`endif
                end
                RUN: begin
                    if (!flush) begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (count == LAST) result_q <= final_value;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall  = ((state == IDLE) & accept) | (state == RUN);
    assign busy   = (state == RUN) | (state == DONE);
    assign done   = (state == DONE);
    assign result = result_q;

endmodule
